gcd_issue: RTL

Operand-issue stage placed directly upstream of `hgcd`. Buffers (a, b) operand pairs from a producer in a small FIFO and launches them into `hgcd` with single-cycle `ld` pulses. Credit-limits launches so that at most `MAXOUT` jobs are outstanding, counting each `rdy` pulse from `hgcd` as a returned credit. Replaces the hand-coded "issue only while nld < nrdy + 2" throttling used by benches, making it a reusable hardware block.

---
 rtl/gcd_issue.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gcd_issue.sv
// gcd_issue -- operand-issue stage feeding an hgcd core.
//
// Buffers (a, b) operand pairs in a small circular FIFO and launches them
// into hgcd with single-cycle ld pulses. Launches are credit-limited so at
// most MAXOUT jobs are inside hgcd at once. Each rdy pulse from hgcd returns
// one credit.
//
// Parameters:
//   W       operand width (matches hgcd a/b)
//   DEPTH   FIFO entries, power of two, >= 2
//   MAXOUT  maximum jobs in flight, 1..7
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all state
//   in_valid     producer offers {in_a, in_b}
//   in_ready     FIFO not full (decoded from registered pointers only)
//   in_a, in_b   operand pair from the producer
//   ld           registered launch pulse to hgcd.ld
//   a, b         registered operands to hgcd, valid while ld=1
//   rdy          one pulse per job completed by hgcd
//   outstanding  jobs launched but not yet returned
//   level        FIFO occupancy
//   err          sticky; set by a rdy that arrives with nothing outstanding
//
// Optional feature, macro GCD_ISSUE_STATS_EN:
//   n_issued     16-bit wrapping count of launches
//   n_done       16-bit wrapping count of rdy pulses that did not set err
module gcd_issue #(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int MAXOUT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic                     ld,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  input  logic                     rdy,
  output logic [2:0]               outstanding,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
`ifdef GCD_ISSUE_STATS_EN
  ,
  output logic [15:0]              n_issued,
  output logic [15:0]              n_done
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Each entry packs {a, b}.
  logic [2*W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  logic           full;
  logic           empty;
  logic           push;
  logic           rdy_ok;
  logic [2:0]     eff;
  logic           launch;
  logic [2*W-1:0] head;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // A rdy in this cycle frees its credit for this cycle's launch decision.
  // A rdy with nothing outstanding is an error and returns no credit.
  assign rdy_ok   = rdy && (outstanding != 3'd0);
  assign eff      = outstanding - {2'b00, rdy_ok};
  assign launch   = !empty && (eff < 3'(MAXOUT));

  assign head     = mem[rd_ptr[AW-1:0]];

  // Storage has no reset so it can map onto distributed/block RAM; stale
  // contents are never observed because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ld          <= 1'b0;
      a           <= '0;
      b           <= '0;
      outstanding <= 3'd0;
      level       <= '0;
      err         <= 1'b0;
    end else begin
      ld <= launch;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
        a      <= head[2*W-1:W];
        b      <= head[W-1:0];
      end
      outstanding <= eff + {2'b00, launch};
      case ({push, launch})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (rdy && (outstanding == 3'd0)) begin
        err <= 1'b1;
      end
    end
  end

`ifdef GCD_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_issued <= 16'd0;
      n_done   <= 16'd0;
    end else begin
      if (launch) begin
        n_issued <= n_issued + 16'd1;
      end
      if (rdy_ok) begin
        n_done <= n_done + 16'd1;
      end
    end
  end
`endif

endmodule
